// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: segment widths and derived totals/active-window starts
// for the supported video modes. All totals must fit the 11-bit coordinate counters.
package vga_timing_pkg;

    localparam int ADDR_W = 11;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA_H_SYNC      = 128;
    localparam int SVGA_H_BACK      = 88;
    localparam int SVGA_H_ACTIVE    = 800;
    localparam int SVGA_H_FRONT     = 40;
    localparam int SVGA_V_SYNC      = 4;
    localparam int SVGA_V_BACK      = 23;
    localparam int SVGA_V_ACTIVE    = 600;
    localparam int SVGA_V_FRONT     = 1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BACK       = 48;
    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FRONT      = 16;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BACK       = 33;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FRONT      = 10;

    // Sum of the four segments of one dimension
    function automatic int seg_total(input int sync_w, input int back_w,
                                     input int act_w, input int front_w);
        return sync_w + back_w + act_w + front_w;
    endfunction

    localparam int SVGA_H_TOTAL     = seg_total(SVGA_H_SYNC, SVGA_H_BACK, SVGA_H_ACTIVE, SVGA_H_FRONT);
    localparam int SVGA_V_TOTAL     = seg_total(SVGA_V_SYNC, SVGA_V_BACK, SVGA_V_ACTIVE, SVGA_V_FRONT);
    localparam int SVGA_H_ACT_START = SVGA_H_SYNC + SVGA_H_BACK;
    localparam int SVGA_V_ACT_START = SVGA_V_SYNC + SVGA_V_BACK;

    localparam int VGA_H_TOTAL      = seg_total(VGA_H_SYNC, VGA_H_BACK, VGA_H_ACTIVE, VGA_H_FRONT);
    localparam int VGA_V_TOTAL      = seg_total(VGA_V_SYNC, VGA_V_BACK, VGA_V_ACTIVE, VGA_V_FRONT);
    localparam int VGA_H_ACT_START  = VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_ACT_START  = VGA_V_SYNC + VGA_V_BACK;

endpackage

// File: rtl/vga_timing_counter.sv
// Modulo-TOTAL counter with count enable; wrap is high on the enabled cycle
// in which the count returns from TOTAL-1 to 0.
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = SVGA_H_TOTAL
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL - 1);

    assign wrap = en && (count == LAST);

    // Advance on enable, folding back to zero after the last count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_module.sv
// VGA sync generator: free-running horizontal/vertical counters, decoded into
// sync pulses, active-video qualifier and zero-based pixel coordinates. All
// outputs are registered one stage after the counters so they stay coherent.
module vga_sync_module
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = SVGA_H_SYNC,
    parameter int   H_BACK   = SVGA_H_BACK,
    parameter int   H_ACTIVE = SVGA_H_ACTIVE,
    parameter int   H_FRONT  = SVGA_H_FRONT,
    parameter int   V_SYNC   = SVGA_V_SYNC,
    parameter int   V_BACK   = SVGA_V_BACK,
    parameter int   V_ACTIVE = SVGA_V_ACTIVE,
    parameter int   V_FRONT  = SVGA_V_FRONT,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              hsync_sig,
    output logic              vsync_sig,
    output logic              ready_sig,
    output logic [ADDR_W-1:0] column_addr_sig,
    output logic [ADDR_W-1:0] row_addr_sig,
    output logic              frame_start_sig
);

    localparam int H_TOTAL = seg_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int V_TOTAL = seg_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

    localparam logic [ADDR_W-1:0] H_SYNC_END  = ADDR_W'(H_SYNC);
    localparam logic [ADDR_W-1:0] H_ACT_START = ADDR_W'(H_SYNC + H_BACK);
    localparam logic [ADDR_W-1:0] H_ACT_END   = ADDR_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [ADDR_W-1:0] V_SYNC_END  = ADDR_W'(V_SYNC);
    localparam logic [ADDR_W-1:0] V_ACT_START = ADDR_W'(V_SYNC + V_BACK);
    localparam logic [ADDR_W-1:0] V_ACT_END   = ADDR_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic [ADDR_W-1:0] h_cnt;
    logic [ADDR_W-1:0] v_cnt;
    logic              h_wrap;
    logic              v_wrap;
    logic              at_origin_reg;

    logic              hsync_next;
    logic              vsync_next;
    logic              ready_next;
    logic [ADDR_W-1:0] column_next;
    logic [ADDR_W-1:0] row_next;
    logic              h_act;
    logic              v_act;

    vga_timing_counter #(.TOTAL(H_TOTAL)) u_h_counter (
        .clk   (clk),
        .rstn  (rstn),
        .en    (1'b1),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    vga_timing_counter #(.TOTAL(V_TOTAL)) u_v_counter (
        .clk   (clk),
        .rstn  (rstn),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    // Tracks "counters sit at (0,0)": true out of reset and on the cycle after a frame wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            at_origin_reg <= 1'b1;
        end else begin
            at_origin_reg <= v_wrap;
        end
    end

    // Decode the current counter position into next output values
    always_comb begin
        h_act       = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
        v_act       = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
        ready_next  = h_act && v_act;
        hsync_next  = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync_next  = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        column_next = '0;
        row_next    = '0;
        if (ready_next) begin
            column_next = h_cnt - H_ACT_START;
            row_next    = v_cnt - V_ACT_START;
        end
    end

    // Output register stage; syncs idle at their deasserted level in reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsync_sig       <= ~SYNC_POL;
            vsync_sig       <= ~SYNC_POL;
            ready_sig       <= 1'b0;
            column_addr_sig <= '0;
            row_addr_sig    <= '0;
            frame_start_sig <= 1'b0;
        end else begin
            hsync_sig       <= hsync_next;
            vsync_sig       <= vsync_next;
            ready_sig       <= ready_next;
            column_addr_sig <= column_next;
            row_addr_sig    <= row_next;
            frame_start_sig <= at_origin_reg;
        end
    end

endmodule

// File: tb/tb_vga_sync_module.sv
// Bench for vga_sync_module: a default 800x600 instance plus two small-geometry
// instances (positive and negative sync polarity) checked every cycle against an
// arithmetic position model, with directed measurements of the key timings.
module tb_vga_sync_module;

    // Small geometry: H 3+2+6+2 = 13, V 2+2+4+1 = 9, frame 117
    localparam int SH_S = 3, SH_B = 2, SH_A = 6, SH_F = 2;
    localparam int SV_S = 2, SV_B = 2, SV_A = 4, SV_F = 1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        rdy;
        logic [10:0] col;
        logic [10:0] row;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_s = 1'b0;
    logic chk_en = 1'b0;

    logic hs_a, vs_a, rdy_a, fs_a;
    logic hs_s, vs_s, rdy_s, fs_s;
    logic hs_p, vs_p, rdy_p, fs_p;
    logic [10:0] col_a, row_a, col_s, row_s, col_p, row_p;

    int na = 0;
    int ns = 0;
    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    vga_sync_module dut_a (
        .clk(clk), .rstn(rst_a),
        .hsync_sig(hs_a), .vsync_sig(vs_a), .ready_sig(rdy_a),
        .column_addr_sig(col_a), .row_addr_sig(row_a), .frame_start_sig(fs_a)
    );

    vga_sync_module #(
        .H_SYNC(SH_S), .H_BACK(SH_B), .H_ACTIVE(SH_A), .H_FRONT(SH_F),
        .V_SYNC(SV_S), .V_BACK(SV_B), .V_ACTIVE(SV_A), .V_FRONT(SV_F),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rstn(rst_s),
        .hsync_sig(hs_s), .vsync_sig(vs_s), .ready_sig(rdy_s),
        .column_addr_sig(col_s), .row_addr_sig(row_s), .frame_start_sig(fs_s)
    );

    vga_sync_module #(
        .H_SYNC(SH_S), .H_BACK(SH_B), .H_ACTIVE(SH_A), .H_FRONT(SH_F),
        .V_SYNC(SV_S), .V_BACK(SV_B), .V_ACTIVE(SV_A), .V_FRONT(SV_F),
        .SYNC_POL(1'b0)
    ) dut_p (
        .clk(clk), .rstn(rst_s),
        .hsync_sig(hs_p), .vsync_sig(vs_p), .ready_sig(rdy_p),
        .column_addr_sig(col_p), .row_addr_sig(row_p), .frame_start_sig(fs_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for the idx-th clock after reset release (idx 0 shows position (0,0))
    function automatic exp_t model(input int hsw, input int hb, input int ha, input int hf,
                                   input int vsw, input int vb, input int va, input int vf,
                                   input logic pol, input int idx);
        int   ht, vt, p, h, v;
        logic act;
        exp_t e;
        ht    = hsw + hb + ha + hf;
        vt    = vsw + vb + va + vf;
        p     = idx % (ht * vt);
        h     = p % ht;
        v     = p / ht;
        act   = (h >= hsw + hb) && (h < hsw + hb + ha) && (v >= vsw + vb) && (v < vsw + vb + va);
        e.hs  = (h < hsw) ? pol : ~pol;
        e.vs  = (v < vsw) ? pol : ~pol;
        e.rdy = act;
        e.col = act ? 11'(h - hsw - hb) : 11'd0;
        e.row = act ? 11'(v - vsw - vb) : 11'd0;
        e.fs  = (p == 0);
        return e;
    endfunction

    function automatic exp_t model_a(input int idx);
        return model(128, 88, 800, 40, 4, 23, 600, 1, 1'b1, idx);
    endfunction

    function automatic exp_t model_s(input logic pol, input int idx);
        return model(SH_S, SH_B, SH_A, SH_F, SV_S, SV_B, SV_A, SV_F, pol, idx);
    endfunction

    function automatic exp_t reset_val(input logic pol);
        exp_t e;
        e     = '0;
        e.hs  = ~pol;
        e.vs  = ~pol;
        return e;
    endfunction

    // Clocks elapsed since each reset was released
    always @(posedge clk) begin
        na <= rst_a ? na + 1 : 0;
        ns <= rst_s ? ns + 1 : 0;
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_a", 32'({hs_a, vs_a, rdy_a, col_a, row_a, fs_a}),
                  32'(rst_a ? model_a(na - 1) : reset_val(1'b1)));
            check("cyc_s", 32'({hs_s, vs_s, rdy_s, col_s, row_s, fs_s}),
                  32'(rst_s ? model_s(1'b1, ns - 1) : reset_val(1'b1)));
            check("cyc_p", 32'({hs_p, vs_p, rdy_p, col_p, row_p, fs_p}),
                  32'(rst_s ? model_s(1'b0, ns - 1) : reset_val(1'b0)));
            check("pol_inv", 32'({hs_p, vs_p, rdy_p, col_p, row_p, fs_p}),
                  32'({~hs_s, ~vs_s, rdy_s, col_s, row_s, fs_s}));
        end
    end

    initial begin
        exp_t e;
        int   fs_per, max_row, max_col, rs_first;
        bit   found;
        int   hs_hi, hs_rise2, last_hs_rise, vs_hi, rdy_first, rdy_off;
        int   rdy_col0, rdy_row0, run_len, last_col, col_after;
        logic hs0, vs0, fs0, hs_prev;
        bit   run_done;

        // Model pinned to hand-computed default-mode points
        e = model_a(0);
        check("pin_origin", 32'({e.hs, e.vs, e.fs}), 32'b111);
        e = model_a(27 * 1056 + 216);
        check("pin_first_act", 32'({e.rdy, e.col, e.row}), 32'({1'b1, 11'd0, 11'd0}));
        e = model_a(27 * 1056 + 1015);
        check("pin_last_col", 32'({e.rdy, e.col}), 32'({1'b1, 11'd799}));
        e = model_a(626 * 1056 + 216);
        check("pin_last_row", 32'({e.rdy, e.row}), 32'({1'b1, 11'd599}));
        e = model_a(626 * 1056 + 1016);
        check("pin_after_act", 32'({e.rdy, e.col, e.row}), 32'd0);

        // Reset held for 5 cycles
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hsync", 32'(hs_a), 32'd0);
        check("rst_vsync", 32'(vs_a), 32'd0);
        check("rst_ready", 32'(rdy_a), 32'd0);
        check("rst_addr", 32'({col_a, row_a}), 32'd0);
        check("rst_hsync_neg", 32'(hs_p), 32'd1);

        // Small geometry: release, frame period, extents
        #2 rst_s = 1'b1;
        @(negedge clk);
        check("s_first", 32'({hs_s, vs_s, fs_s}), 32'b111);
        check("p_first", 32'({hs_p, vs_p, fs_p}), 32'b001);
        fs_per = 0; max_row = 0; max_col = 0;
        for (int k = 1; k < 250; k++) begin
            @(negedge clk);
            if (fs_s && fs_per == 0) fs_per = k;
            if (rdy_s && int'(row_s) > max_row) max_row = int'(row_s);
            if (rdy_s && int'(col_s) > max_col) max_col = int'(col_s);
        end
        check("s_frame_period", 32'(fs_per), 32'd117);
        check("s_max_row", 32'(max_row), 32'd3);
        check("s_max_col", 32'(max_col), 32'd5);

        // Small geometry: mid-frame asynchronous reset
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (rdy_s && row_s == 11'd2 && col_s == 11'd3) found = 1'b1;
        end
        check("s_mid_wait", 32'(found), 32'd1);
        #2 rst_s = 1'b0;
        #1;
        check("s_mid_async", 32'({hs_s, vs_s, rdy_s, col_s, row_s, fs_s}), 32'd0);
        check("p_mid_async", 32'({hs_p, vs_p}), 32'b11);
        repeat (3) @(negedge clk);
        #2 rst_s = 1'b1;
        rs_first = -1;
        for (int k = 0; k < 300 && rs_first < 0; k++) begin
            @(negedge clk);
            if (rdy_s) begin
                rs_first = k;
                check("s_restart_addr", 32'({col_s, row_s}), 32'd0);
            end
        end
        check("s_restart_ready", 32'(rs_first), 32'(4 * 13 + 5));

        // Default 800x600: release and measure the first frame's timings
        @(negedge clk);
        #2 rst_a = 1'b1;
        hs_hi = 0; hs_rise2 = -1; last_hs_rise = 0; vs_hi = 0; rdy_first = -1; rdy_off = -1;
        rdy_col0 = -1; rdy_row0 = -1; run_len = 0; last_col = -1; col_after = -1;
        hs0 = 1'b0; vs0 = 1'b0; fs0 = 1'b0; hs_prev = 1'b0; run_done = 1'b0;
        for (int k = 0; k < 29600; k++) begin
            @(negedge clk);
            if (k == 0) begin
                hs0 = hs_a; vs0 = vs_a; fs0 = fs_a;
            end
            if (k < 1056 && hs_a) hs_hi++;
            if (hs_a && !hs_prev) begin
                if (k > 0 && hs_rise2 < 0) hs_rise2 = k;
                last_hs_rise = k;
            end
            hs_prev = hs_a;
            if (vs_a) vs_hi++;
            if (rdy_a && rdy_first < 0) begin
                rdy_first = k;
                rdy_off   = k - last_hs_rise;
                rdy_col0  = int'(col_a);
                rdy_row0  = int'(row_a);
            end
            if (rdy_first >= 0 && !run_done) begin
                if (rdy_a) begin
                    run_len++;
                    last_col = int'(col_a);
                end else begin
                    run_done  = 1'b1;
                    col_after = int'(col_a);
                end
            end
        end
        check("a_first", 32'({hs0, vs0, fs0}), 32'b111);
        check("a_hsync_width", 32'(hs_hi), 32'd128);
        check("a_line_period", 32'(hs_rise2), 32'd1056);
        check("a_vsync_width", 32'(vs_hi), 32'd4224);
        check("a_first_ready", 32'(rdy_first), 32'(27 * 1056 + 216));
        check("a_ready_offset", 32'(rdy_off), 32'd216);
        check("a_first_addr", 32'({rdy_col0, rdy_row0}), 32'd0);
        check("a_ready_len", 32'(run_len), 32'd800);
        check("a_last_col", 32'(last_col), 32'd799);
        check("a_col_after", 32'(col_after), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
